// File: rtl/sos_section_sequencer_pkg.sv
// Shared constants for the SOS section sequencer: coefficient select codes,
// unity coefficient value and FSM state encodings.
package sos_section_sequencer_pkg;

    localparam int unsigned COEF_ONE  = 262144;
    localparam int unsigned NUM_COEFS = 6;

    localparam logic [2:0] SEL_B0   = 3'd0;
    localparam logic [2:0] SEL_B1   = 3'd1;
    localparam logic [2:0] SEL_B2   = 3'd2;
    localparam logic [2:0] SEL_A1   = 3'd3;
    localparam logic [2:0] SEL_A2   = 3'd4;
    localparam logic [2:0] SEL_GAIN = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    function automatic int unsigned sec_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sos_section_sequencer_coef_bank.sv
// Per-section coefficient storage with one write port and one read port.
// The read port forwards a same-cycle write so a sample started together with a write sees it.
module sos_section_sequencer_coef_bank
    import sos_section_sequencer_pkg::*;
#(
    parameter int unsigned COEF_SIZE    = 20,
    parameter int unsigned NUM_SECTIONS = 2,
    parameter int unsigned SEC_W        = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [SEC_W-1:0]               wr_sec,
    input  logic [2:0]                     wr_sel,
    input  logic [COEF_SIZE-1:0]           wr_data,
    input  logic [SEC_W-1:0]               rd_sec,
    output logic [NUM_COEFS*COEF_SIZE-1:0] rd_coef_c
);

    logic [COEF_SIZE-1:0] coef_q [NUM_SECTIONS][NUM_COEFS];

    // Reset leaves every section as a unity-gain passthrough.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
                for (int c = 0; c < int'(NUM_COEFS); c++) begin
                    coef_q[s][c] <= (3'(c) == SEL_B0 || 3'(c) == SEL_GAIN)
                                    ? COEF_SIZE'(COEF_ONE) : '0;
                end
            end
        end else if (wr_en) begin
            coef_q[wr_sec][wr_sel] <= wr_data;
        end
    end

    always_comb begin
        rd_coef_c = '0;
        for (int c = 0; c < int'(NUM_COEFS); c++) begin
            rd_coef_c[c*COEF_SIZE +: COEF_SIZE] = coef_q[rd_sec][c];
            if (wr_en && wr_sec == rd_sec && wr_sel == 3'(c)) begin
                rd_coef_c[c*COEF_SIZE +: COEF_SIZE] = wr_data;
            end
        end
    end

endmodule

// File: rtl/sos_section_sequencer.sv
// Time-multiplexes one external biquad engine across a cascade of SOS sections,
// holding per-section history and coefficients and chaining each output to the next section.
module sos_section_sequencer
    import sos_section_sequencer_pkg::*;
#(
    parameter int unsigned  DATA_SIZE    = 24,
    parameter int unsigned  COEF_SIZE    = 20,
    parameter int unsigned  NUM_SECTIONS = 2,
    parameter int unsigned  TIMEOUT      = 64,
    localparam int unsigned SEC_W        = sec_width(NUM_SECTIONS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_trig,
    input  logic [DATA_SIZE-1:0]           data_in,
    output logic [DATA_SIZE-1:0]           data_out,
    output logic                           filter_done,
    output logic                           busy,
    input  logic                           cfg_we,
    input  logic [SEC_W-1:0]               cfg_sec,
    input  logic [2:0]                     cfg_sel,
    input  logic [COEF_SIZE-1:0]           cfg_data,
    input  logic                           status_clr,
    output logic                           overrun,
    output logic                           cfg_err,
    output logic                           timeout_err,
    output logic                           eng_start,
    output logic [DATA_SIZE-1:0]           eng_x,
    output logic [DATA_SIZE-1:0]           eng_x1,
    output logic [DATA_SIZE-1:0]           eng_x2,
    output logic [DATA_SIZE-1:0]           eng_y1,
    output logic [DATA_SIZE-1:0]           eng_y2,
    output logic [NUM_COEFS*COEF_SIZE-1:0] eng_coef,
    input  logic [DATA_SIZE-1:0]           eng_y,
    input  logic                           eng_done
);

    localparam int unsigned      WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(NUM_SECTIONS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    logic [1:0]                     state_q, state_d;
    logic [SEC_W-1:0]               sec_q, sec_d;
    logic [WD_W-1:0]                wdog_q, wdog_d;
    logic [DATA_SIZE-1:0]           x_d, data_out_d;
    logic                           filter_done_d;
    logic                           load_ops, hist_we, timeout_set;
    logic                           cfg_ok, overrun_d, cfg_err_d, timeout_d;
    logic [NUM_COEFS*COEF_SIZE-1:0] coef_rd_c;

    logic [DATA_SIZE-1:0] hist_x1 [NUM_SECTIONS];
    logic [DATA_SIZE-1:0] hist_x2 [NUM_SECTIONS];
    logic [DATA_SIZE-1:0] hist_y1 [NUM_SECTIONS];
    logic [DATA_SIZE-1:0] hist_y2 [NUM_SECTIONS];

    sos_section_sequencer_coef_bank #(
        .COEF_SIZE    (COEF_SIZE),
        .NUM_SECTIONS (NUM_SECTIONS),
        .SEC_W        (SEC_W)
    ) u_coef_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (cfg_ok),
        .wr_sec    (cfg_sec),
        .wr_sel    (cfg_sel),
        .wr_data   (cfg_data),
        .rd_sec    (sec_d),
        .rd_coef_c (coef_rd_c)
    );

    // Next-state, operand-load and flag logic.
    always_comb begin
        state_d       = state_q;
        sec_d         = sec_q;
        wdog_d        = wdog_q;
        x_d           = eng_x;
        data_out_d    = data_out;
        filter_done_d = 1'b0;
        load_ops      = 1'b0;
        hist_we       = 1'b0;
        timeout_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample_trig) begin
                    x_d      = data_in;
                    sec_d    = '0;
                    load_ops = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    hist_we = 1'b1;
                    x_d     = eng_y;
                    if (sec_q == SEC_LAST) begin
                        data_out_d    = eng_y;
                        filter_done_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        sec_d    = sec_q + SEC_W'(1);
                        load_ops = 1'b1;
                        state_d  = ST_START;
                    end
                end else if (wdog_q == WD_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cfg_ok    = cfg_we && (state_q == ST_IDLE) && (32'(cfg_sec) < NUM_SECTIONS)
                    && (cfg_sel <= SEL_GAIN);
        // A set event in the same cycle as status_clr keeps the flag high.
        overrun_d = (overrun     && !status_clr) || (sample_trig && state_q != ST_IDLE);
        cfg_err_d = (cfg_err     && !status_clr) || (cfg_we && !cfg_ok);
        timeout_d = (timeout_err && !status_clr) || timeout_set;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sec_q       <= '0;
            wdog_q      <= '0;
            data_out    <= '0;
            filter_done <= 1'b0;
            busy        <= 1'b0;
            eng_start   <= 1'b0;
            overrun     <= 1'b0;
            cfg_err     <= 1'b0;
            timeout_err <= 1'b0;
            eng_x       <= '0;
            eng_x1      <= '0;
            eng_x2      <= '0;
            eng_y1      <= '0;
            eng_y2      <= '0;
            eng_coef    <= '0;
            for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
                hist_x1[s] <= '0;
                hist_x2[s] <= '0;
                hist_y1[s] <= '0;
                hist_y2[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            wdog_q      <= wdog_d;
            data_out    <= data_out_d;
            filter_done <= filter_done_d;
            busy        <= (state_d != ST_IDLE);
            eng_start   <= load_ops;
            overrun     <= overrun_d;
            cfg_err     <= cfg_err_d;
            timeout_err <= timeout_d;
            // Operands are captured on entry to START and held until the engine answers.
            if (load_ops) begin
                eng_x    <= x_d;
                eng_x1   <= hist_x1[sec_d];
                eng_x2   <= hist_x2[sec_d];
                eng_y1   <= hist_y1[sec_d];
                eng_y2   <= hist_y2[sec_d];
                eng_coef <= coef_rd_c;
            end
            if (hist_we) begin
                hist_x1[sec_q] <= eng_x;
                hist_x2[sec_q] <= eng_x1;
                hist_y1[sec_q] <= eng_y;
                hist_y2[sec_q] <= eng_y1;
            end
        end
    end

endmodule

// File: tb/tb_sos_section_sequencer.sv
// Bench for sos_section_sequencer: acts as the biquad engine and checks operands,
// outputs, latency and flags against a per-section history/coefficient model.
module tb_sos_section_sequencer;
    import sos_section_sequencer_pkg::*;

    localparam int unsigned DW = 24;
    localparam int unsigned CW = 20;
    localparam int          NS = 2;
    localparam int          TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, sample_trig, cfg_we, status_clr, eng_done;
    logic [DW-1:0]   data_in, eng_y;
    logic [0:0]      cfg_sec;
    logic [2:0]      cfg_sel;
    logic [CW-1:0]   cfg_data;
    logic [DW-1:0]   data_out, eng_x, eng_x1, eng_x2, eng_y1, eng_y2;
    logic            filter_done, busy, overrun, cfg_err, timeout_err, eng_start;
    logic [6*CW-1:0] eng_coef;

    sos_section_sequencer #(
        .DATA_SIZE(DW), .COEF_SIZE(CW), .NUM_SECTIONS(NS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .sample_trig(sample_trig), .data_in(data_in),
        .data_out(data_out), .filter_done(filter_done), .busy(busy),
        .cfg_we(cfg_we), .cfg_sec(cfg_sec), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .status_clr(status_clr), .overrun(overrun), .cfg_err(cfg_err),
        .timeout_err(timeout_err), .eng_start(eng_start), .eng_x(eng_x),
        .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_y1(eng_y1), .eng_y2(eng_y2),
        .eng_coef(eng_coef), .eng_y(eng_y), .eng_done(eng_done)
    );

    // Reference model: what each section should remember and hold.
    logic [DW-1:0] m_x1 [NS];
    logic [DW-1:0] m_x2 [NS];
    logic [DW-1:0] m_y1 [NS];
    logic [DW-1:0] m_y2 [NS];
    logic [CW-1:0] m_coef [NS][6];
    logic [DW-1:0] m_out;

    int vectors = 0, miscompares = 0;
    int cyc = 0, xtrig_at = -1, cfgb_at = -1, done_seen = 0, starts_seen = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_x1[s] = '0; m_x2[s] = '0; m_y1[s] = '0; m_y2[s] = '0;
            for (int c = 0; c < 6; c++)
                m_coef[s][c] = (c == 0 || c == 5) ? CW'(COEF_ONE) : '0;
        end
        m_out = '0;
    endtask

    function automatic logic [6*CW-1:0] exp_coef(input int s);
        logic [6*CW-1:0] v;
        for (int c = 0; c < 6; c++) v[c*CW +: CW] = m_coef[s][c];
        return v;
    endfunction

    function automatic logic [DW-1:0] eng_fn(input int mode, input logic [DW-1:0] x);
        case (mode)
            0:       return x;
            1:       return x + DW'(1);
            default: return DW'($urandom);
        endcase
    endfunction

    // Advance to the next falling edge; one-cycle strobes drop here.
    task automatic step();
        @(negedge clk);
        cyc++;
        sample_trig = 1'b0; cfg_we = 1'b0; status_clr = 1'b0; eng_done = 1'b0;
        if (filter_done) done_seen++;
        if (eng_start) starts_seen++;
        if (cyc == xtrig_at) begin sample_trig = 1'b1; data_in = DW'($urandom); end
        if (cyc == cfgb_at) begin
            cfg_we = 1'b1; cfg_sec = 1'b0; cfg_sel = SEL_B0; cfg_data = CW'($urandom);
        end
    endtask

    task automatic cfg_write(input int sec, input int sel, input logic [CW-1:0] d, input bit clr);
        cfg_we = 1'b1; cfg_sec = 1'(sec); cfg_sel = 3'(sel); cfg_data = d; status_clr = clr;
        if (sec < NS && sel <= 5) m_coef[sec][sel] = d;
        step();
    endtask

    // One sample through the cascade; abort_kind 1 = engine silent, 2 = reset in WAIT.
    task automatic run_sample(input logic [DW-1:0] d, input int e, input int mode, input bit b2b,
                              input int abort_sec, input int abort_kind);
        logic [DW-1:0] x, y;
        int guard;
        cyc = 0; done_seen = 0; starts_seen = 0;
        sample_trig = 1'b1; data_in = d; x = d;
        for (int s = 0; s < NS; s++) begin
            guard = 0;
            step();
            while (!eng_start && guard < 8) begin step(); guard++; end
            if (!eng_start) begin chk("eng_start_seen", 128'(0), 128'(1)); return; end
            chk("start_cycle", 128'(cyc), 128'(1 + s * (e + 1)));
            chk("busy_run", 128'(busy), 128'(1));
            chk("eng_x",  128'(eng_x),  128'(x));
            chk("eng_x1", 128'(eng_x1), 128'(m_x1[s]));
            chk("eng_x2", 128'(eng_x2), 128'(m_x2[s]));
            chk("eng_y1", 128'(eng_y1), 128'(m_y1[s]));
            chk("eng_y2", 128'(eng_y2), 128'(m_y2[s]));
            chk("eng_coef", 128'(eng_coef), 128'(exp_coef(s)));
            if (s == abort_sec && abort_kind == 1) begin
                repeat (TO) step();
                chk("to_busy_last_wait", 128'(busy), 128'(1));
                chk("to_flag_early", 128'(timeout_err), 128'(0));
                step();
                chk("to_busy_after", 128'(busy), 128'(0));
                chk("to_flag", 128'(timeout_err), 128'(1));
                chk("to_data_out", 128'(data_out), 128'(m_out));
                chk("to_no_done", 128'(done_seen), 128'(0));
                return;
            end
            if (s == abort_sec && abort_kind == 2) begin
                step();
                reset = 1'b0;
                step();
                reset = 1'b1;
                model_reset();
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_data_out", 128'(data_out), 128'(0));
                chk("rst_done", 128'(done_seen), 128'(0));
                chk("rst_flags", 128'({overrun, cfg_err, timeout_err, eng_start}), 128'(0));
                return;
            end
            repeat (e) step();
            y = eng_fn(mode, x);
            eng_done = 1'b1; eng_y = y;
            m_x2[s] = m_x1[s]; m_x1[s] = x; m_y2[s] = m_y1[s]; m_y1[s] = y;
            x = y;
        end
        step();
        m_out = x;
        chk("filter_done", 128'(filter_done), 128'(1));
        chk("latency", 128'(cyc), 128'(NS * (e + 1) + 1));
        chk("data_out", 128'(data_out), 128'(m_out));
        if (b2b) return;
        repeat (3) step();
        chk("done_count", 128'(done_seen), 128'(1));
        chk("start_count", 128'(starts_seen), 128'(NS));
        chk("idle_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        reset = 1'b0; sample_trig = 1'b0; cfg_we = 1'b0; status_clr = 1'b0; eng_done = 1'b0;
        data_in = '0; eng_y = '0; cfg_sec = '0; cfg_sel = '0; cfg_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({busy, filter_done, eng_start, overrun, cfg_err, timeout_err}), 128'(0));
        chk("reset_data_out", 128'(data_out), 128'(0));
        reset = 1'b1;
        step();

        // Passthrough engine, default coefficients.
        run_sample(DW'(1000), 3, 0, 0, -1, 0);
        chk("out_1000", 128'(data_out), 128'(1000));

        // y = x + 1 engine; third sample exposes the section-1 history.
        run_sample(DW'(5), 3, 1, 0, -1, 0);
        chk("out_7", 128'(data_out), 128'(7));
        run_sample(DW'(6), 2, 1, 0, -1, 0);
        chk("out_8", 128'(data_out), 128'(8));
        run_sample(DW'($urandom), 1, 2, 0, -1, 0);

        // Overrun: second trig two cycles in is dropped.
        xtrig_at = 2;
        run_sample(DW'($urandom), 2, 2, 0, -1, 0);
        xtrig_at = -1;
        chk("overrun_set", 128'(overrun), 128'(1));
        status_clr = 1'b1; step();
        chk("overrun_clr", 128'(overrun), 128'(0));

        // Valid config write in IDLE, then sample sees A1 of section 1.
        cfg_write(1, int'(SEL_A1), CW'(524683), 0);
        chk("cfg_ok_noerr", 128'(cfg_err), 128'(0));
        run_sample(DW'($urandom), 2, 2, 0, -1, 0);

        // Write in the same cycle as the trig is used by that sample.
        cfg_we = 1'b1; cfg_sec = 1'b0; cfg_sel = SEL_A2; cfg_data = CW'($urandom);
        m_coef[0][4] = cfg_data;
        run_sample(DW'($urandom), 1, 2, 0, -1, 0);
        chk("cfg_sametrig_noerr", 128'(cfg_err), 128'(0));

        // Write while busy is rejected, bank unchanged on the next sample.
        cfgb_at = 3;
        run_sample(DW'($urandom), 2, 2, 0, -1, 0);
        cfgb_at = -1;
        chk("cfg_busy_err", 128'(cfg_err), 128'(1));
        run_sample(DW'($urandom), 1, 2, 0, -1, 0);
        status_clr = 1'b1; step();
        chk("cfg_err_clr", 128'(cfg_err), 128'(0));

        // Invalid select with a simultaneous clear: set wins.
        cfg_write(0, 6, CW'($urandom), 1);
        chk("cfg_sel6_err", 128'(cfg_err), 128'(1));
        status_clr = 1'b1; step();
        cfg_write(1, 7, CW'($urandom), 0);
        chk("cfg_sel7_err", 128'(cfg_err), 128'(1));
        status_clr = 1'b1; step();
        chk("cfg_err_clr2", 128'(cfg_err), 128'(0));

        // eng_done while idle is ignored.
        eng_done = 1'b1; eng_y = DW'($urandom); step(); step();
        chk("stray_done_busy", 128'(busy), 128'(0));
        chk("stray_done_out", 128'({filter_done, data_out}), 128'({1'b0, m_out}));

        // Trig in the filter_done cycle is accepted.
        run_sample(DW'($urandom), 2, 2, 1, -1, 0);
        run_sample(DW'($urandom), 3, 2, 0, -1, 0);
        chk("b2b_no_overrun", 128'(overrun), 128'(0));

        // Randomized samples with interleaved coefficient writes.
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                cfg_write(int'($urandom_range(NS - 1, 0)), int'($urandom_range(5, 0)),
                          CW'($urandom), 0);
                chk("rand_cfg_noerr", 128'(cfg_err), 128'(0));
            end
            run_sample(DW'($urandom), int'($urandom_range(5, 1)), 2, 0, -1, 0);
        end

        // Engine silent in section 1: timeout, section-1 history untouched.
        run_sample(DW'($urandom), 2, 2, 0, 1, 1);
        run_sample(DW'($urandom), 2, 2, 0, -1, 0);
        status_clr = 1'b1; step();
        chk("timeout_clr", 128'(timeout_err), 128'(0));

        // Reset during section-1 WAIT, then defaults visible on the next sample.
        cfg_write(1, int'(SEL_B1), CW'($urandom), 0);
        run_sample(DW'($urandom), 3, 2, 0, 1, 2);
        run_sample(DW'($urandom), 2, 2, 0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
